// File: rtl/led_shift_driver.sv
// led_shift_driver
// Serializes a parallel LED/GPIO word, MSB first, onto an external
// 74HC595-style shift-register chain. A write that arrives while a frame is
// in flight is parked in a one-deep pending buffer (last write wins). That
// word is sent straight after the current frame's latch pulse.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   load    one-cycle strobe, capture par_in
//   par_in  parallel word to serialize
//   sclk    serial shift clock (DIV cycles low, DIV cycles high per bit)
//   sdata   serial data, changes only when sclk goes low
//   slatch  storage-register latch pulse, DIV cycles wide
//   busy    high while a frame is shifted or latched
//   done    one-cycle pulse when a frame's latch pulse closes
module led_shift_driver #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] par_in,
    output logic             sclk,
    output logic             sdata,
    output logic             slatch,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = $clog2(DIV) + 1;
    localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   pend_word_q, pend_word_d;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               sdata_q, sdata_d;
    logic               slatch_q, slatch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Frame start is shared by IDLE and the LATCH-close handoff.
    logic               start_en;
    logic [WIDTH-1:0]   start_word;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        pend_word_d = pend_word_q;
        pend_d      = pend_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        slatch_d    = slatch_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_en    = 1'b0;
        start_word  = par_in;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    start_en   = 1'b1;
                    start_word = par_in;
                end
            end

            StShift: begin
                if (load) begin
                    pend_d      = 1'b1;
                    pend_word_d = par_in;
                end
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q != BIT_LAST) begin
                            bit_d   = bit_q + BIT_W'(1);
                            sdata_d = sreg_q[WIDTH-2];
                            sreg_d  = sreg_q << 1;
                        end else begin
                            sdata_d  = 1'b0;
                            slatch_d = 1'b1;
                            state_d  = StLatch;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            StLatch: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    slatch_d = 1'b0;
                    done_d   = 1'b1;
                    // A load on the closing edge is newer than any pending word.
                    if (load || pend_q) begin
                        start_en   = 1'b1;
                        start_word = load ? par_in : pend_word_q;
                        pend_d     = 1'b0;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                    if (load) begin
                        pend_d      = 1'b1;
                        pend_word_d = par_in;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        if (start_en) begin
            state_d = StShift;
            sreg_d  = start_word;
            sdata_d = start_word[WIDTH-1];
            sclk_d  = 1'b0;
            busy_d  = 1'b1;
            div_d   = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            pend_word_q <= '0;
            pend_q      <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            slatch_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            pend_word_q <= pend_word_d;
            pend_q      <= pend_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
            slatch_q    <= slatch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sclk   = sclk_q;
    assign sdata  = sdata_q;
    assign slatch = slatch_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: a WIDTH=8/DIV=2 instance driven with a table of
// single frames plus hand-written multi-cycle sequences, and a WIDTH=2/DIV=1
// instance for the smallest-parameter corner.
module tb_led_shift_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] par_in = 8'h00;
    logic       sclk, sdata, slatch, busy, done;

    logic       load2 = 1'b0;
    logic [1:0] par_in2 = 2'b00;
    logic       sclk2, sdata2, slatch2, busy2, done2;

    always #5 clk = ~clk;

    led_shift_driver #(.WIDTH(8), .DIV(2)) dut (
        .clk(clk), .rst(rst), .load(load), .par_in(par_in),
        .sclk(sclk), .sdata(sdata), .slatch(slatch), .busy(busy), .done(done)
    );

    led_shift_driver #(.WIDTH(2), .DIV(1)) dut2 (
        .clk(clk), .rst(rst), .load(load2), .par_in(par_in2),
        .sclk(sclk2), .sdata(sdata2), .slatch(slatch2), .busy(busy2), .done(done2)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Monitor: running totals sampled mid-cycle.
    int          busy_cnt = 0, rise_cnt = 0, latch_cnt = 0, done_cnt = 0, fall_cnt = 0;
    int          viol_hold = 0, viol_overlap = 0, viol_idle = 0;
    logic [31:0] cap = '0;
    logic        sclk_p = 1'b0, sdata_p = 1'b0, busy_p = 1'b0;

    always @(negedge clk) begin
        busy_cnt  <= busy_cnt + int'(busy);
        latch_cnt <= latch_cnt + int'(slatch);
        done_cnt  <= done_cnt + int'(done);
        if (busy_p && !busy) fall_cnt <= fall_cnt + 1;
        if (sclk && !sclk_p) begin
            rise_cnt <= rise_cnt + 1;
            cap      <= {cap[30:0], sdata};
        end
        if (sclk && sclk_p && (sdata != sdata_p)) viol_hold <= viol_hold + 1;
        if (sclk && slatch) viol_overlap <= viol_overlap + 1;
        if (sclk && !busy) viol_idle <= viol_idle + 1;
        sclk_p  <= sclk;
        sdata_p <= sdata;
        busy_p  <= busy;
    end

    int b_busy, b_rise, b_latch, b_done, b_fall;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic snap();
        b_busy  = busy_cnt;
        b_rise  = rise_cnt;
        b_latch = latch_cnt;
        b_done  = done_cnt;
        b_fall  = fall_cnt;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [7:0] d);
        par_in = d;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    // Wait until n more done pulses have been seen, bounded by limit cycles.
    task automatic wait_done(input int n, input int limit, input string name);
        int start = done_cnt;
        for (int i = 0; i < limit; i++) begin
            if (done_cnt - start >= n) return;
            tick();
        end
        check(name, done_cnt - start, n);
    endtask

    typedef struct {
        logic [7:0] data;
        int         exp_busy;
    } frame_vec_t;

    frame_vec_t vecs[5];

    initial begin
        vecs[0] = '{data: 8'hA5, exp_busy: 34};
        vecs[1] = '{data: 8'h3C, exp_busy: 34};
        vecs[2] = '{data: 8'h00, exp_busy: 34};
        vecs[3] = '{data: 8'hFF, exp_busy: 34};
        vecs[4] = '{data: 8'h81, exp_busy: 34};

        // Reset: 3 cycles, then idle.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_sclk", int'(sclk), 0);
        check("reset_sdata", int'(sdata), 0);
        check("reset_slatch", int'(slatch), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        snap();
        repeat (20) tick();
        check("idle_sclk_rises", rise_cnt - b_rise, 0);
        check("idle_busy", busy_cnt - b_busy, 0);

        // Table of single frames.
        foreach (vecs[k]) begin
            snap();
            pulse_load(vecs[k].data);
            wait_done(1, 60, "frame_timeout");
            tick();
            check($sformatf("frame%0d_busy", k), busy_cnt - b_busy, vecs[k].exp_busy);
            check($sformatf("frame%0d_rises", k), rise_cnt - b_rise, 8);
            check($sformatf("frame%0d_bits", k), int'(cap[7:0]), int'(vecs[k].data));
            check($sformatf("frame%0d_latch", k), latch_cnt - b_latch, 2);
            check($sformatf("frame%0d_done", k), done_cnt - b_done, 1);
        end

        // Back-to-back: FF overwritten by 81 before service.
        snap();
        pulse_load(8'h3C);
        repeat (9) tick();
        pulse_load(8'hFF);
        tick();
        pulse_load(8'h81);
        wait_done(2, 120, "b2b_timeout");
        tick();
        check("b2b_busy", busy_cnt - b_busy, 68);
        check("b2b_busy_falls", fall_cnt - b_fall, 1);
        check("b2b_done", done_cnt - b_done, 2);
        check("b2b_rises", rise_cnt - b_rise, 16);
        check("b2b_bits", int'(cap[15:0]), 16'h3C81);

        // Reset mid-frame with a pending word queued.
        snap();
        pulse_load(8'hF0);
        repeat (4) tick();
        pulse_load(8'h99);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sclk", int'(sclk), 0);
        check("midrst_sdata", int'(sdata), 0);
        check("midrst_slatch", int'(slatch), 0);
        check("midrst_busy", int'(busy), 0);
        snap();
        repeat (60) tick();
        check("midrst_no_pending_rises", rise_cnt - b_rise, 0);
        check("midrst_no_pending_busy", busy_cnt - b_busy, 0);

        // Load on the edge that closes LATCH: no idle gap.
        snap();
        pulse_load(8'h12);
        for (int i = 0; i < 60 && !slatch; i++) tick();
        check("close_latch_seen", int'(slatch), 1);
        tick();
        check("close_latch_last", int'(slatch), 1);
        pulse_load(8'h55);
        check("close_done_with_busy", int'(done && busy), 1);
        wait_done(1, 60, "close_timeout");
        tick();
        check("close_busy", busy_cnt - b_busy, 68);
        check("close_busy_falls", fall_cnt - b_fall, 1);
        check("close_bits", int'(cap[15:0]), 16'h1255);

        check("sdata_hold_violations", viol_hold, 0);
        check("sclk_slatch_overlap", viol_overlap, 0);
        check("sclk_in_idle", viol_idle, 0);

        // Smallest parameters: WIDTH=2, DIV=1.
        begin
            int       busy2_n = 0, hi_n = 0, done2_n = 0;
            logic [1:0] hi_bits = '0;
            par_in2 = 2'b10;
            load2   = 1'b1;
            tick();
            load2   = 1'b0;
            for (int i = 0; i < 12; i++) begin
                busy2_n += int'(busy2);
                done2_n += int'(done2);
                if (sclk2) begin
                    hi_n++;
                    hi_bits = {hi_bits[0], sdata2};
                end
                tick();
            end
            check("w2_busy", busy2_n, 5);
            check("w2_high_cycles", hi_n, 2);
            check("w2_bits", int'(hi_bits), 2);
            check("w2_done", done2_n, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
